// File: rtl/i_mem_responder.sv
// i_mem_responder
//   Memory-side responder for the instruction cache miss port. A miss request
//   (m_strobe/m_a) turns into one 32-bit read on the downstream instruction
//   bus (b_*). The returned word is presented on m_dout together with a
//   single-cycle m_ready pulse. If the bus never returns data, a timeout
//   answers with TO_DATA and pulses bus_err.
//
//   Optional feature: define I_RESP_PREFETCH_EN to add a one-word sequential
//   prefetch buffer. After every response, the word at req_addr+4 is fetched.
//   Without the macro, pf_inv is ignored and RESP always returns to IDLE.
//
// Parameters
//   A_WIDTH  address width (matches cache m_a)
//   TIMEOUT  max DATA cycles waiting for b_rvalid; 0 disables the timeout
//   TO_DATA  word returned to the cache on a timeout
//
// Ports
//   clk       in   clock, rising edge
//   clrn      in   asynchronous active-low reset
//   m_a       in   miss address (bits [1:0] ignored)
//   m_strobe  in   miss request level, held until m_ready
//   m_dout    out  read data, valid while m_ready=1
//   m_ready   out  one-cycle response pulse
//   b_req     out  bus read request, held until b_gnt
//   b_addr    out  bus read address, word aligned
//   b_gnt     in   bus accepted the request
//   b_rvalid  in   bus read data valid
//   b_rdata   in   bus read data
//   bus_err   out  one-cycle pulse when a demand read times out
//   pf_inv    in   invalidate prefetch buffer
module i_mem_responder #(
   parameter int          A_WIDTH = 32,
   parameter int          TIMEOUT = 255,
   parameter logic [31:0] TO_DATA = 32'h0000_0000
) (
   input  logic               clk,
   input  logic               clrn,
   input  logic [A_WIDTH-1:0] m_a,
   input  logic               m_strobe,
   output logic [31:0]        m_dout,
   output logic               m_ready,
   output logic               b_req,
   output logic [A_WIDTH-1:0] b_addr,
   input  logic               b_gnt,
   input  logic               b_rvalid,
   input  logic [31:0]        b_rdata,
   output logic               bus_err,
   input  logic               pf_inv
);

   // The counter must hold TIMEOUT without wrapping.
   // It keeps at least one bit even when the timeout is disabled.
   localparam int CNT_MAX = (TIMEOUT == 0) ? 1 : TIMEOUT;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam logic [CW-1:0] CNT_TOP  = CW'(CNT_MAX);
   localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);

   typedef enum logic [2:0] {
      ST_IDLE, ST_ADDR, ST_DATA, ST_RESP, ST_PF_ADDR, ST_PF_DATA
   } state_t;

   state_t             state_reg, state_next;
   logic [A_WIDTH-1:0] req_addr_reg, req_addr_next;
   logic [CW-1:0]      cnt_reg, cnt_next;
   logic [31:0]        m_dout_reg, m_dout_next;
   logic               m_ready_reg, m_ready_next;
   logic               b_req_reg, b_req_next;
   logic [A_WIDTH-1:0] b_addr_reg, b_addr_next;
   logic               bus_err_reg, bus_err_next;
   logic [A_WIDTH-1:0] m_word;

`ifdef I_RESP_PREFETCH_EN
   logic [A_WIDTH-1:0] pf_addr_reg, pf_addr_next;
   logic [31:0]        pf_data_reg, pf_data_next;
   logic               pf_valid_reg, pf_valid_next;
   logic               pf_discard_reg, pf_discard_next;
   logic               pf_drop;
`endif

   // Address byte-offset bits carry no information.
   // In the default build, pf_inv has no effect.
   logic unused_bits;
   assign unused_bits = ^{pf_inv, m_a[1:0]};

   assign m_word = {m_a[A_WIDTH-1:2], 2'b00};

   always_comb begin
      state_next    = state_reg;
      req_addr_next = req_addr_reg;
      cnt_next      = cnt_reg;
      m_dout_next   = m_dout_reg;
      m_ready_next  = 1'b0;
      b_req_next    = b_req_reg;
      b_addr_next   = b_addr_reg;
      bus_err_next  = 1'b0;
`ifdef I_RESP_PREFETCH_EN
      pf_addr_next    = pf_addr_reg;
      pf_data_next    = pf_data_reg;
      pf_valid_next   = pf_valid_reg;
      pf_discard_next = pf_discard_reg;
      // A same-cycle invalidate also poisons prefetch data that is landing now.
      pf_drop         = pf_discard_reg | pf_inv;
`endif
      case (state_reg)
         ST_IDLE: begin
`ifdef I_RESP_PREFETCH_EN
            // Buffer hit: answer without touching the bus.
            // A same-cycle invalidate turns the hit into a miss.
            if (m_strobe && pf_valid_reg && !pf_inv && m_word == pf_addr_reg) begin
               m_dout_next   = pf_data_reg;
               req_addr_next = pf_addr_reg;
               pf_valid_next = 1'b0;
               m_ready_next  = 1'b1;
               state_next    = ST_RESP;
            end else
`endif
            if (m_strobe) begin
               req_addr_next = m_word;
               b_req_next    = 1'b1;
               b_addr_next   = m_word;
               state_next    = ST_ADDR;
            end
         end
         ST_ADDR: begin
            if (b_gnt) begin
               b_req_next = 1'b0;
               cnt_next   = '0;
               state_next = ST_DATA;
            end
         end
         ST_DATA: begin
            if (b_rvalid) begin
               m_dout_next  = b_rdata;
               m_ready_next = 1'b1;
               state_next   = ST_RESP;
            end else begin
               if (cnt_reg != CNT_TOP) cnt_next = cnt_reg + CW'(1);
               // This would be the TIMEOUT-th empty DATA cycle, so give up now.
               if (TIMEOUT != 0 && cnt_reg == CNT_LAST) begin
                  m_dout_next  = TO_DATA;
                  bus_err_next = 1'b1;
                  m_ready_next = 1'b1;
                  state_next   = ST_RESP;
               end
            end
         end
         ST_RESP: begin
`ifdef I_RESP_PREFETCH_EN
            pf_addr_next    = req_addr_reg + A_WIDTH'(4);
            b_addr_next     = req_addr_reg + A_WIDTH'(4);
            b_req_next      = 1'b1;
            pf_valid_next   = 1'b0;
            pf_discard_next = 1'b0;
            state_next      = ST_PF_ADDR;
`else
            state_next = ST_IDLE;
`endif
         end
`ifdef I_RESP_PREFETCH_EN
         ST_PF_ADDR: begin
            if (b_gnt) begin
               b_req_next = 1'b0;
               cnt_next   = '0;
               state_next = ST_PF_DATA;
            end
         end
         ST_PF_DATA: begin
            if (b_rvalid) begin
               if (m_strobe && !pf_drop && m_word == pf_addr_reg) begin
                  // A demand arrived for the word in flight: forward it directly.
                  m_dout_next   = b_rdata;
                  m_ready_next  = 1'b1;
                  req_addr_next = pf_addr_reg;
                  state_next    = ST_RESP;
               end else if (m_strobe) begin
                  req_addr_next = m_word;
                  b_req_next    = 1'b1;
                  b_addr_next   = m_word;
                  state_next    = ST_ADDR;
               end else begin
                  pf_data_next  = b_rdata;
                  pf_valid_next = !pf_drop;
                  state_next    = ST_IDLE;
               end
            end else begin
               if (cnt_reg != CNT_TOP) cnt_next = cnt_reg + CW'(1);
               // A prefetch timeout is dropped silently.
               // Any waiting demand is then picked up in IDLE.
               if (TIMEOUT != 0 && cnt_reg == CNT_LAST) state_next = ST_IDLE;
            end
         end
`endif
         default: state_next = ST_IDLE;
      endcase
`ifdef I_RESP_PREFETCH_EN
      if (pf_inv) begin
         pf_valid_next   = 1'b0;
         pf_discard_next = 1'b1;
      end
`endif
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         state_reg    <= ST_IDLE;
         req_addr_reg <= '0;
         cnt_reg      <= '0;
         m_dout_reg   <= '0;
         m_ready_reg  <= 1'b0;
         b_req_reg    <= 1'b0;
         b_addr_reg   <= '0;
         bus_err_reg  <= 1'b0;
`ifdef I_RESP_PREFETCH_EN
         pf_addr_reg    <= '0;
         pf_data_reg    <= '0;
         pf_valid_reg   <= 1'b0;
         pf_discard_reg <= 1'b0;
`endif
      end else begin
         state_reg    <= state_next;
         req_addr_reg <= req_addr_next;
         cnt_reg      <= cnt_next;
         m_dout_reg   <= m_dout_next;
         m_ready_reg  <= m_ready_next;
         b_req_reg    <= b_req_next;
         b_addr_reg   <= b_addr_next;
         bus_err_reg  <= bus_err_next;
`ifdef I_RESP_PREFETCH_EN
         pf_addr_reg    <= pf_addr_next;
         pf_data_reg    <= pf_data_next;
         pf_valid_reg   <= pf_valid_next;
         pf_discard_reg <= pf_discard_next;
`endif
      end
   end

   assign m_dout  = m_dout_reg;
   assign m_ready = m_ready_reg;
   assign b_req   = b_req_reg;
   assign b_addr  = b_addr_reg;
   assign bus_err = bus_err_reg;

endmodule

// File: tb/tb_i_mem_responder.sv
// Testbench for i_mem_responder (default build, prefetch disabled).
// The expected response timing and data are derived per transaction from the
// bus handshake the bench itself drives:
//   - request seen in cycle 0
//   - b_req held in cycles 1..1+g, with the grant in cycle 1+g
//   - data in DATA cycle r, or a timeout after TO empty DATA cycles
//   - m_ready in cycle 2+g+min(r,TO)
module tb_i_mem_responder;
   localparam int          AW  = 32;
   localparam int          TO  = 4;
   localparam logic [31:0] TOD = 32'h0000_0000;

   logic          clk = 1'b0;
   logic          clrn = 1'b0;
   logic [AW-1:0] m_a = '0;
   logic          m_strobe = 1'b0;
   logic [31:0]   m_dout;
   logic          m_ready;
   logic          b_req;
   logic [AW-1:0] b_addr;
   logic          b_gnt = 1'b0;
   logic          b_rvalid = 1'b0;
   logic [31:0]   b_rdata = '0;
   logic          bus_err;
   logic          pf_inv = 1'b0;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   i_mem_responder #(.A_WIDTH(AW), .TIMEOUT(TO), .TO_DATA(TOD)) dut (
      .clk(clk), .clrn(clrn), .m_a(m_a), .m_strobe(m_strobe),
      .m_dout(m_dout), .m_ready(m_ready), .b_req(b_req), .b_addr(b_addr),
      .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
      .bus_err(bus_err), .pf_inv(pf_inv)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // One demand read.
   //   g     = cycles the grant is withheld
   //   r     = DATA cycle carrying rvalid; r > TO means the bus never answers
   //   noise = also toggle ignored inputs and wobble the cache side while busy
   task automatic run_txn(input logic [31:0] addr, input int g, input int r,
                          input logic [31:0] rd, input bit noise);
      bit          to;
      int          resp;
      logic [31:0] wa;
      logic [31:0] exp_d;
      to    = (r > TO);
      resp  = 2 + g + (to ? TO : r);
      wa    = {addr[31:2], 2'b00};
      exp_d = to ? TOD : rd;
      for (int c = 0; c <= resp + 1; c++) begin
         @(posedge clk); #1;
         if (c == 0) begin
            m_strobe = 1'b1;
            m_a      = addr;
         end else if (c <= resp) begin
            if (noise && $urandom_range(0, 3) == 0) begin
               m_strobe = 1'($urandom_range(0, 1));
               m_a      = $urandom;
            end
         end else begin
            m_strobe = 1'b0;
         end
         b_gnt    = (c == 1 + g);
         b_rvalid = (!to && c == 1 + g + r);
         b_rdata  = b_rvalid ? rd : $urandom;
         if (noise) begin
            if ((c == 0 || c >= 2 + g) && $urandom_range(0, 1) == 1) b_gnt = 1'b1;
            if (c <= 1 + g && $urandom_range(0, 1) == 1) b_rvalid = 1'b1;
         end
         @(negedge clk);
         chk("b_req", {31'b0, b_req}, {31'b0, (c >= 1 && c <= 1 + g)});
         if (c >= 1 && c <= 1 + g) chk("b_addr", b_addr, wa);
         chk("m_ready", {31'b0, m_ready}, {31'b0, (c == resp)});
         chk("bus_err", {31'b0, bus_err}, {31'b0, (c == resp && to)});
         if (c == resp) chk("m_dout", m_dout, exp_d);
      end
      $display("txn addr=0x%08h gnt_wait=%0d rvalid_cycle=%0d timeout=%0d latency=%0d data=0x%08h",
               addr, g, r, to, resp, exp_d);
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         m_strobe = 1'b0;
         b_gnt    = 1'($urandom_range(0, 1));
         b_rvalid = 1'($urandom_range(0, 1));
         b_rdata  = $urandom;
         @(negedge clk);
         chk("idle_b_req", {31'b0, b_req}, 32'd0);
         chk("idle_m_ready", {31'b0, m_ready}, 32'd0);
         chk("idle_bus_err", {31'b0, bus_err}, 32'd0);
      end
   endtask

   initial begin
      // Reset state.
      #12;
      chk("rst_m_ready", {31'b0, m_ready}, 32'd0);
      chk("rst_m_dout", m_dout, 32'd0);
      chk("rst_b_req", {31'b0, b_req}, 32'd0);
      chk("rst_b_addr", b_addr, 32'd0);
      chk("rst_bus_err", {31'b0, bus_err}, 32'd0);
      @(negedge clk);
      clrn = 1'b1;

      // Directed cases.
      run_txn(32'h0000_1004, 0, 1, 32'h2408_0001, 1'b0);   // minimum latency
      run_txn(32'h0000_2008, 5, 3, 32'hDEAD_BEEF, 1'b0);   // slow grant
      run_txn(32'h0000_300C, 1, TO + 1, 32'h1111_1111, 1'b0); // timeout
      run_txn(32'h0000_3010, 0, TO, 32'h2222_2222, 1'b0);  // rvalid on last DATA cycle
      run_txn(32'h0000_4013, 2, 2, 32'h3333_3333, 1'b0);   // low address bits ignored
      run_txn(32'hFFFF_FFFE, 0, 1, 32'h4444_4444, 1'b1);   // top of address space

      // Randomized traffic.
      for (int i = 0; i < 40; i++) begin
         run_txn($urandom, $urandom_range(0, 4), $urandom_range(1, TO + 2), $urandom, 1'b1);
         if ($urandom_range(0, 2) == 0) idle_cycles($urandom_range(1, 2));
      end

      // Asynchronous reset in the middle of a read.
      run_txn(32'h0000_5000, 0, 1, 32'hA5A5_A5A5, 1'b0);
      @(posedge clk); #1;
      m_strobe = 1'b1; m_a = 32'h0000_6004; b_gnt = 1'b0; b_rvalid = 1'b0;
      @(posedge clk); #1;
      b_gnt = 1'b1;
      @(negedge clk);
      chk("pre_rst_b_req", {31'b0, b_req}, 32'd1);
      @(posedge clk); #1;
      b_gnt = 1'b0; m_strobe = 1'b0;
      @(negedge clk); #1;
      clrn = 1'b0;
      #1;
      chk("async_m_dout", m_dout, 32'd0);
      chk("async_b_addr", b_addr, 32'd0);
      chk("async_b_req", {31'b0, b_req}, 32'd0);
      chk("async_m_ready", {31'b0, m_ready}, 32'd0);
      chk("async_bus_err", {31'b0, bus_err}, 32'd0);
      @(posedge clk); #1;
      b_rvalid = 1'b1; b_rdata = 32'h7777_7777;
      @(negedge clk);
      clrn = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         b_rvalid = 1'b1;
         @(negedge clk);
         chk("no_stray_m_ready", {31'b0, m_ready}, 32'd0);
         chk("no_stray_b_req", {31'b0, b_req}, 32'd0);
      end
      b_rvalid = 1'b0;
      run_txn(32'h0000_7008, 1, 2, 32'h5555_5555, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   // Hard time limit so the run can never hang.
   initial begin
      #200000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "watchdog");
   end
endmodule
